// File: rtl/cache_pkg.sv
// Shared flush-state encoding and derived-width helpers for the write-back cache.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      WB   = 2'd2,
      DONE = 2'd3
   } flush_state_t;

   function automatic int unsigned calc_sb(input int unsigned lines);
      return $clog2(lines);
   endfunction

   function automatic int unsigned calc_ob(input int unsigned bwords);
      return $clog2(bwords);
   endfunction

   function automatic int unsigned calc_wb(input int unsigned ways);
      return $clog2(ways);
   endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim choice and most-recent update for a touched way.
module plru_tree
   import cache_pkg::*;
#(
   parameter int unsigned WAYS = 4
) (
   input  logic [WAYS-2:0]          bits,
   input  logic [calc_wb(WAYS)-1:0] touch,
   output logic [calc_wb(WAYS)-1:0] victim_c,
   output logic [WAYS-2:0]          updated_c
);

   localparam int unsigned WIDX = calc_wb(WAYS);

   // Heap node n sits at bit n-1; tree level l branches on way-index bit l.
   always_comb begin
      logic [WIDX:0] node;
      victim_c = '0;
      node     = (WIDX+1)'(1);
      for (int l = 0; l < WIDX; l++) begin
         victim_c[l] = bits[WIDX'(node - (WIDX+1)'(1))];
         node        = {node[WIDX-1:0], victim_c[l]};
      end
   end

   // Every node on the touched path is pointed away from the touched way.
   always_comb begin
      logic [WIDX:0] node;
      updated_c = bits;
      node      = (WIDX+1)'(1);
      for (int l = 0; l < WIDX; l++) begin
         updated_c[WIDX'(node - (WIDX+1)'(1))] = ~touch[l];
         node = {node[WIDX-1:0], touch[l]};
      end
   end

endmodule

// File: rtl/data_writeback_nway_cache_memory.sv
// N-way set-associative write-back data array with tree-PLRU replacement
// and a flush engine that sweeps every entry, offering dirty blocks for writeback.
module data_writeback_nway_cache_memory
   import cache_pkg::*;
#(
   parameter int unsigned WAYS   = 4,
   parameter int unsigned LINES  = 16,
   parameter int unsigned TBITS  = 22,
   parameter int unsigned BWORDS = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [31:0]               addr,
   input  logic [TBITS-1:0]          phys_tag,
   input  logic                      access,
   input  logic                      we,
   input  logic [WAYS-1:0]           way_sel,
   input  logic [31:0]               wd,
   input  logic [3:0]                byte_mask,
   input  logic                      vin,
   input  logic                      dirty_in,
   output logic                      hit,
   output logic [WAYS-1:0]           hit_way,
   output logic [31:0]               rd,
   output logic [WAYS-1:0]           victim_way,
   output logic                      victim_valid,
   output logic                      victim_dirty,
   output logic [TBITS-1:0]          victim_tag,
   input  logic                      flush_start,
   input  logic                      flush_inv,
   output logic                      flush_busy,
   output logic                      wb_valid,
   input  logic                      wb_ready,
   output logic [calc_sb(LINES)-1:0] wb_set,
   output logic [TBITS-1:0]          wb_tag,
   output logic [BWORDS*32-1:0]      wb_block,
   output logic                      flush_done
);

   localparam int unsigned SB   = calc_sb(LINES);
   localparam int unsigned OB   = calc_ob(BWORDS);
   localparam int unsigned WIDX = calc_wb(WAYS);
   localparam int unsigned IW   = SB + WIDX;

   logic [31:0]      data_q  [WAYS][LINES][BWORDS];
   logic [TBITS-1:0] tag_q   [WAYS][LINES];
   logic [LINES-1:0] valid_q [WAYS];
   logic [LINES-1:0] dirty_q [WAYS];
   logic [WAYS-2:0]  plru_q  [LINES];

   flush_state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          inv_q, inv_d;
   logic          clr_dirty_c, clr_valid_c;

   logic [SB-1:0]   set_c;
   logic [OB-1:0]   word_c;
   logic [SB-1:0]   idx_set_c;
   logic [WIDX-1:0] idx_way_c;
   logic            busy_c, wr_c, plru_upd_c, hit_any_c;
   logic [WIDX-1:0] hit_idx_c, wsel_idx_c, victim_idx_c, touch_c, plru_victim_c;
   logic [WAYS-2:0] plru_next_c;
   logic            unused_addr_c;

   assign set_c         = addr[OB+SB+1:OB+2];
   assign word_c        = addr[OB+1:2];
   assign unused_addr_c = ^{addr[31:OB+SB+2], addr[1:0]};
   assign idx_set_c     = idx_q[IW-1:WIDX];
   assign idx_way_c     = idx_q[WIDX-1:0];

   assign busy_c     = (state_q != IDLE);
   assign flush_busy = busy_c;
   assign wb_valid   = (state_q == WB);
   assign flush_done = (state_q == DONE);

   // Tag match; the descending scan leaves the lowest matching way.
   always_comb begin
      hit_idx_c = '0;
      hit_any_c = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[w][set_c] && (tag_q[w][set_c] == phys_tag)) begin
            hit_idx_c = WIDX'(w);
            hit_any_c = 1'b1;
         end
      end
   end

   always_comb begin
      wsel_idx_c = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (way_sel[w]) wsel_idx_c = WIDX'(w);
      end
   end

   // An invalid way always beats the PLRU choice.
   always_comb begin
      victim_idx_c = plru_victim_c;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][set_c]) victim_idx_c = WIDX'(w);
      end
   end

   always_comb begin
      hit_way    = '0;
      victim_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         hit_way[w]    = hit && (hit_idx_c == WIDX'(w));
         victim_way[w] = (victim_idx_c == WIDX'(w));
      end
   end

   assign hit          = hit_any_c & ~busy_c;
   assign rd           = hit ? data_q[hit_idx_c][set_c][word_c] : 32'h0;
   assign victim_valid = valid_q[victim_idx_c][set_c];
   assign victim_dirty = dirty_q[victim_idx_c][set_c];
   assign victim_tag   = tag_q[victim_idx_c][set_c];

   assign wr_c       = we && !busy_c && (|way_sel);
   assign touch_c    = wr_c ? wsel_idx_c : hit_idx_c;
   assign plru_upd_c = wr_c || (access && hit);

   plru_tree #(.WAYS(WAYS)) u_plru (
      .bits      (plru_q[set_c]),
      .touch     (touch_c),
      .victim_c  (plru_victim_c),
      .updated_c (plru_next_c)
   );

   assign wb_set = idx_set_c;
   assign wb_tag = tag_q[idx_way_c][idx_set_c];
   for (genvar b = 0; b < BWORDS; b++) begin : g_wb_block
      assign wb_block[32*b +: 32] = data_q[idx_way_c][idx_set_c][b];
   end

   // Line state: CPU writes only while idle, flush updates only while busy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            dirty_q[w] <= '0;
         end
         for (int s = 0; s < LINES; s++) plru_q[s] <= '0;
      end else begin
         if (wr_c) begin
            valid_q[wsel_idx_c][set_c] <= vin;
            dirty_q[wsel_idx_c][set_c] <= dirty_in;
         end
         if (plru_upd_c) plru_q[set_c] <= plru_next_c;
         if (clr_dirty_c) dirty_q[idx_way_c][idx_set_c] <= 1'b0;
         if (clr_valid_c) valid_q[idx_way_c][idx_set_c] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset && wr_c) begin
         tag_q[wsel_idx_c][set_c] <= phys_tag;
         for (int b = 0; b < 4; b++) begin
            if (byte_mask[b]) data_q[wsel_idx_c][set_c][word_c][8*b +: 8] <= wd[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         inv_q   <= inv_d;
      end
   end

   // Sweep order is set-major: the way index forms the low bits of idx.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      inv_d       = inv_q;
      clr_dirty_c = 1'b0;
      clr_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush_start) begin
               state_d = SCAN;
               idx_d   = '0;
               inv_d   = flush_inv;
            end
         end
         SCAN: begin
            if (dirty_q[idx_way_c][idx_set_c]) begin
               state_d = WB;
            end else begin
               clr_valid_c = inv_q;
               idx_d       = idx_q + IW'(1);
               if (&idx_q) state_d = DONE;
            end
         end
         WB: begin
            if (wb_ready) begin
               clr_dirty_c = 1'b1;
               clr_valid_c = inv_q;
               idx_d       = idx_q + IW'(1);
               state_d     = (&idx_q) ? DONE : SCAN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/data_writeback_nway_cache_memory.md
DATA_WRITEBACK_NWAY_CACHE_MEMORY -- requirements
Module: data_writeback_nway_cache_memory

Interface
REQ-001 SHALL have parameter WAYS, default 4: associativity, power of 2, range 2..8.
REQ-002 SHALL have parameter LINES, default 16: sets per way, power of 2; SB = log2(LINES).
REQ-003 SHALL have parameter TBITS, default 22: tag width.
REQ-004 SHALL have parameter BWORDS, default 4: 32-bit words per block, power of 2; OB = log2(BWORDS).
REQ-005 SHALL have the following ports, each as name, direction, width, meaning; clock and reset are listed first.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- addr  in  32  byte address; word = addr[OB+1:2], set = addr[OB+SB+1:OB+2].
- phys_tag  in  TBITS  lookup and write tag.
- access  in  1  lookup strobe; updates replacement state on hit.
- we  in  1  write strobe.
- way_sel  in  WAYS  one-hot write target way.
- wd  in  32  write word.
- byte_mask  in  4  byte enables for wd.
- vin, dirty_in  in  1  valid and dirty written with the line.
- hit  out  1  lookup hit.
- hit_way  out  WAYS  one-hot hit way.
- rd  out  32  addressed word of hit way.
- victim_way  out  WAYS  one-hot replacement choice.
- victim_valid, victim_dirty  out  1  state of the victim line.
- victim_tag  out  TBITS  tag of the victim line.
- flush_start, flush_inv  in  1  begin sweep; invalidate during sweep.
- flush_busy  out  1  sweep in progress.
- wb_valid  out  1  writeback offer.
- wb_ready  in  1  writeback accept.
- wb_set  out  SB  set of the offered line.
- wb_tag  out  TBITS  tag of the offered line.
- wb_block  out  BWORDS*32  offered block, word 0 in LSBs.
- flush_done  out  1  one-cycle sweep-complete pulse.

Function
REQ-006 Lookup SHALL be combinational: hit = any way with valid & tag==phys_tag at set; rd = addressed word of that way, 32'h0 on miss; on multiple matches the lowest index SHALL win.
REQ-007 When we=1 and flush_busy=0, at the next edge the way in way_sel SHALL take the masked bytes of wd at the addressed word, tag<=phys_tag, valid<=vin, dirty<=dirty_in; other words are unchanged.
REQ-008 Each set SHALL keep a tree-PLRU of WAYS-1 bits; on we the written way, else on access&hit the hit way, SHALL be marked most-recent at the next edge.
REQ-009 victim_way SHALL be the lowest-index invalid way in the set if one exists, else the PLRU-indicated way; victim_* reflect that line combinationally.
REQ-010 The flush FSM SHALL have states IDLE, SCAN, WB, DONE and SHALL sweep entries in set-major then way order, one entry per SCAN cycle.
REQ-011 IDLE->SCAN on flush_start, clearing the entry index to set 0, way 0 and latching flush_inv; flush_start SHALL be ignored outside IDLE.
REQ-012 In SCAN, a dirty entry SHALL go to WB; a clean entry SHALL be invalidated if flush_inv was latched, then advance; after the last entry the FSM SHALL go to DONE.
REQ-013 In WB, wb_valid=1 and wb_set/wb_tag/wb_block SHALL hold stable until wb_valid&wb_ready.
REQ-014 On that handshake the entry SHALL be cleared dirty (and invalidated if flush_inv was latched), the index SHALL advance, and the FSM SHALL go to SCAN, or to DONE if it was the last entry.
REQ-015 DONE SHALL assert flush_done for exactly one cycle, then go to IDLE.
REQ-016 While flush_busy=1 (SCAN, WB, DONE), we and access SHALL be ignored and hit SHALL be forced to 0.
REQ-017 wb_valid SHALL be 0 outside WB; the outputs in REQ-013 are don't-care when wb_valid=0.
REQ-018 With no dirty lines, a sweep SHALL take WAYS*LINES SCAN cycles plus one DONE cycle.

Reset
REQ-019 When reset=0 at an edge, all valid, dirty and PLRU bits SHALL clear, the FSM SHALL go to IDLE, and the index and latched flush_inv SHALL clear; data and tag arrays are not reset.
REQ-020 After reset: hit=0, rd=0, victim_way=one-hot way 0, victim_valid=0, victim_dirty=0, flush_busy=0, wb_valid=0, flush_done=0.
REQ-021 Reset during a sweep SHALL abort it with no flush_done pulse.

Structure
REQ-022 Shared package cache_pkg SHALL hold the flush-state enum and the derived-width helpers (SB, OB, WB=log2(WAYS)).
REQ-023 The per-set PLRU victim and update logic SHALL be a combinational sub-module plru_tree parameterised by WAYS.

Verification
REQ-024 Reset, write way 2, set 5, word 1 = 32'hDEADBEEF with mask 4'hF, tag 0x123 -> next-cycle lookup: hit=1, hit_way=4'b0100, rd=32'hDEADBEEF.
REQ-025 Byte write with mask 4'b0010, wd=32'h0000AB00 over that word -> rd=32'hDEADABEF.
REQ-026 Fill all 4 ways of set 3, then access ways 0,1,2 -> victim_way=4'b1000, victim_valid=1.
REQ-027 Two dirty lines, flush_inv=1, wb_ready held low 3 cycles on the first offer -> wb fields stable throughout; exactly two handshakes in set/way order; then flush_done pulses once and all lines are invalid.
REQ-028 Reset pulled low while in WB -> next cycle flush_busy=0, wb_valid=0, no flush_done pulse.
REQ-029 we=1 and flush_start in the same cycle while idle -> write commits; sweep then offers that line if dirty_in=1.
